// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_e;

  // The shared timer only ever holds values up to max(...)-1.
  function automatic int unsigned timer_width(input int unsigned rst_cycles,
                                              input int unsigned timeout_cycles,
                                              input int unsigned stable_cycles);
    int unsigned m;
    m = rst_cycles;
    if (timeout_cycles > m) m = timeout_cycles;
    if (stable_cycles > m) m = stable_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_bit_sync.sv
// Multi-flop single-bit synchronizer, asynchronously cleared to 0.
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, lock qualification and downstream system reset release.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned LOSS_CNT_W          = 8,
  parameter int unsigned SYNC_STAGES         = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  input  logic                  retry_req,
  input  logic                  cnt_clr,
  output logic                  pll_rst,
  output logic                  sys_reset_n,
  output logic                  lock_ok,
  output logic                  fault,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic [1:0]            retry_cnt
);

  localparam int unsigned TW = timer_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                           LOCK_STABLE_CYCLES);
  localparam int unsigned FW = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES);

  localparam logic [TW-1:0] RST_LAST  = TW'(RST_PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] STB_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_RETRIES - 1);

  state_e                  state_q;
  logic [TW-1:0]           timer_q;
  logic [FW-1:0]           fail_cnt_q;
  logic [1:0]              retry_cnt_q;
  logic [LOSS_CNT_W-1:0]   loss_cnt_q;
  logic                    pll_rst_q;
  logic                    sys_rst_n_q;
  logic                    lock_ok_q;
  logic                    fault_q;
  logic                    locked_s;

  logic [LOSS_CNT_W-1:0]   loss_base_d;
  logic [LOSS_CNT_W-1:0]   loss_inc_d;
  logic [1:0]              retry_inc_d;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (pll_locked),
    .q_o    (locked_s)
  );

  // A clear applied on the same edge as a loss yields a count of one.
  always_comb begin
    loss_base_d = cnt_clr ? '0 : loss_cnt_q;
    loss_inc_d  = (loss_base_d == '1) ? loss_base_d : loss_base_d + 1'b1;
    retry_inc_d = (retry_cnt_q == 2'b11) ? retry_cnt_q : retry_cnt_q + 2'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESET_PLL;
      timer_q     <= '0;
      fail_cnt_q  <= '0;
      retry_cnt_q <= '0;
      loss_cnt_q  <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      lock_ok_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      loss_cnt_q <= loss_base_d;
      unique case (state_q)
        RESET_PLL: begin
          if (timer_q == RST_LAST) begin
            state_q   <= WAIT_LOCK;
            pll_rst_q <= 1'b0;
            timer_q   <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_q <= STABLE;
            timer_q <= '0;
          end else if (timer_q == TMO_LAST) begin
            retry_cnt_q <= retry_inc_d;
            timer_q     <= '0;
            if (fail_cnt_q == FAIL_LAST) begin
              state_q <= FAULT;
              fault_q <= 1'b1;
            end else begin
              fail_cnt_q <= fail_cnt_q + 1'b1;
              state_q    <= RESET_PLL;
              pll_rst_q  <= 1'b1;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        STABLE: begin
          // A dropout here is treated as a glitch: requalify without resetting the PLL.
          if (!locked_s) begin
            state_q <= WAIT_LOCK;
            timer_q <= '0;
          end else if (timer_q == STB_LAST) begin
            state_q     <= RUN;
            timer_q     <= '0;
            sys_rst_n_q <= 1'b1;
            lock_ok_q   <= 1'b1;
            retry_cnt_q <= '0;
            fail_cnt_q  <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_q     <= RESET_PLL;
            timer_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            lock_ok_q   <= 1'b0;
            loss_cnt_q  <= loss_inc_d;
          end
        end
        FAULT: begin
          if (retry_req) begin
            state_q     <= RESET_PLL;
            timer_q     <= '0;
            pll_rst_q   <= 1'b1;
            fault_q     <= 1'b0;
            retry_cnt_q <= '0;
            fail_cnt_q  <= '0;
          end
        end
        default: begin
          state_q     <= RESET_PLL;
          timer_q     <= '0;
          pll_rst_q   <= 1'b1;
          sys_rst_n_q <= 1'b0;
          lock_ok_q   <= 1'b0;
          fault_q     <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_reset_n   = sys_rst_n_q;
  assign lock_ok       = lock_ok_q;
  assign fault         = fault_q;
  assign lock_loss_cnt = loss_cnt_q;
  assign retry_cnt     = retry_cnt_q;

endmodule
